prbs_seq_ctrl: RTL and testbench



---
 rtl/prbs_seq_pkg.sv | 14 +
 rtl/prbs3_core.sv | 29 ++
 rtl/prbs_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_prbs_seq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/prbs_seq_pkg.sv
// Shared types and constants for the PRBS sequencer and its 3-stage engine.
package prbs_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } prbs_seq_state_t;

   localparam int PRBS_SEED_W      = 3;
   localparam int PRBS_LOAD_CYCLES = 3;

endpackage

// File: rtl/prbs3_core.sv
// 3-stage XOR-feedback shift register: c -> d -> out, feedback c^d,
// serial seed input selected when ena is low.
module prbs3_core (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic seed,
   output logic out
);

   logic c;
   logic d;
   logic b;

   assign b = ena ? (c ^ d) : seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c   <= 1'b0;
         d   <= 1'b0;
         out <= 1'b0;
      end else begin
         c   <= b;
         d   <= c;
         out <= d;
      end
   end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Sequencer for prbs3_core: serially seeds the engine, collects len output
// bits into res_data and returns them over valid/ready.
// Optional abort input enabled with `define PRBS_SEQ_CTRL_ABORT_EN.
module prbs_seq_ctrl
   import prbs_seq_pkg::*;
#(
   parameter int OUT_W = 8,
   parameter int LEN_W = $clog2(OUT_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [2:0]       seed,
   input  logic [LEN_W-1:0] len,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [OUT_W-1:0] res_data,
   output logic             busy
`ifdef PRBS_SEQ_CTRL_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam logic [LEN_W-1:0] OUT_W_LEN = LEN_W'(OUT_W);
   localparam logic [1:0]       LOAD_LAST = 2'(PRBS_LOAD_CYCLES - 1);

   prbs_seq_state_t state;
   prbs_seq_state_t state_nxt;

   logic [PRBS_SEED_W-1:0] seed_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       len_eff;
   logic [LEN_W-1:0]       cnt;
   logic [1:0]             ld_cnt;
   logic                   accept;
   logic                   load_last;
   logic                   run_last;
   logic                   abort_hit;
   logic                   eng_ena;
   logic                   eng_seed;
   logic                   eng_out;

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = (state == LOAD) || (state == RUN);
   assign accept      = start_valid && start_ready;
   assign load_last   = (ld_cnt == LOAD_LAST);
   assign run_last    = (cnt == (len_q - LEN_W'(1)));
   assign len_eff     = ((len == '0) || (len > OUT_W_LEN)) ? OUT_W_LEN : len;

`ifdef PRBS_SEQ_CTRL_ABORT_EN
   assign abort_hit = abort && busy;
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = LOAD;
         LOAD:    if (load_last) state_nxt = RUN;
         RUN:     if (run_last)  state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
      if (abort_hit) begin
         state_nxt = IDLE;
      end
   end

   // Seed goes in MSB first so that after three shifts out holds seed[2].
   always_comb begin
      eng_seed = seed_q[0];
      case (ld_cnt)
         2'd0:    eng_seed = seed_q[2];
         2'd1:    eng_seed = seed_q[1];
         default: eng_seed = seed_q[0];
      endcase
   end

   assign eng_ena = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_q   <= '0;
         len_q    <= '0;
         cnt      <= '0;
         ld_cnt   <= '0;
         res_data <= '0;
      end else if (accept) begin
         seed_q   <= seed;
         len_q    <= len_eff;
         cnt      <= '0;
         ld_cnt   <= '0;
         res_data <= '0;
      end else if (abort_hit) begin
         cnt      <= '0;
         ld_cnt   <= '0;
         res_data <= '0;
      end else if (state == LOAD) begin
         ld_cnt <= ld_cnt + 2'd1;
      end else if (state == RUN) begin
         res_data <= res_data | ({{(OUT_W-1){1'b0}}, eng_out} << cnt);
         // Hold cnt on the final bit so it never exceeds OUT_W-1.
         if (!run_last) begin
            cnt <= cnt + LEN_W'(1);
         end
      end
   end

   prbs3_core u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (eng_ena),
      .seed  (eng_seed),
      .out   (eng_out)
   );

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed, table-driven bench for prbs_seq_ctrl (OUT_W=8).
module tb_prbs_seq_ctrl;

   localparam int OUT_W = 8;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [2:0]       seed;
   logic [LEN_W-1:0] len;
   logic             res_valid;
   logic             res_ready;
   logic [OUT_W-1:0] res_data;
   logic             busy;
`ifdef PRBS_SEQ_CTRL_ABORT_EN
   logic             abort;
`endif

   always #5 clk = ~clk;

   prbs_seq_ctrl #(.OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .seed        (seed),
      .len         (len),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy)
`ifdef PRBS_SEQ_CTRL_ABORT_EN
      ,
      .abort       (abort)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]       seed;
      logic [LEN_W-1:0] len;
      logic [OUT_W-1:0] data;
      int               lat;
      int               hold;
   } vec_t;

   vec_t vecs[6];

   // Called with inputs stable between edges; returns #1 after the edge that leaves DONE.
   task automatic run_vec(input vec_t v);
      int lat;
      logic [OUT_W-1:0] held;
      seed        = v.seed;
      len         = v.len;
      start_valid = 1'b1;
      check("start_ready_idle", start_ready, 1);
      @(posedge clk); #1;
      check("busy_after_accept", busy, 1);
      // Requests while busy must be ignored; res_ready outside DONE too.
      seed      = 3'b111;
      len       = 4'd2;
      res_ready = (v.hold == 0);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (res_valid) break;
      end
      res_ready = 1'b0;
      check("latency", lat, v.lat);
      check("res_data", res_data, v.data);
      check("busy_done", busy, 0);
      check("start_ready_done", start_ready, 0);
      held = res_data;
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, held);
         check("hold_start_ready", start_ready, 0);
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("idle_res_valid", res_valid, 0);
      check("idle_start_ready", start_ready, 1);
   endtask

   initial begin
      vecs[0] = '{seed: 3'b110, len: 4'd8,  data: 8'hDB, lat: 11, hold: 0};
      vecs[1] = '{seed: 3'b001, len: 4'd0,  data: 8'h6C, lat: 11, hold: 0};
      vecs[2] = '{seed: 3'b110, len: 4'd5,  data: 8'h1B, lat: 8,  hold: 0};
      vecs[3] = '{seed: 3'b000, len: 4'd8,  data: 8'h00, lat: 11, hold: 10};
      vecs[4] = '{seed: 3'b110, len: 4'd15, data: 8'hDB, lat: 11, hold: 2};
      vecs[5] = '{seed: 3'b110, len: 4'd1,  data: 8'h01, lat: 4,  hold: 0};

      rst_n       = 1'b0;
      start_valid = 1'b1;
      seed        = 3'b110;
      len         = 4'd8;
      res_ready   = 1'b0;
`ifdef PRBS_SEQ_CTRL_ABORT_EN
      abort       = 1'b0;
`endif

      // Start held high through reset: nothing may be accepted.
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_start_ready", start_ready, 1);
         check("rst_busy", busy, 0);
         check("rst_res_valid", res_valid, 0);
         check("rst_res_data", res_data, 0);
      end
      rst_n = 1'b1;
      run_vec(vecs[0]);

      for (int i = 1; i < 6; i++) begin
         run_vec(vecs[i]);
      end

      // Asynchronous reset in the middle of RUN discards the partial word.
      seed        = 3'b110;
      len         = 4'd8;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_valid", res_valid, 0);
      check("midrun_rst_data", res_data, 0);
      check("midrun_rst_ready", start_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_vec(vecs[0]);

`ifdef PRBS_SEQ_CTRL_ABORT_EN
      // Abort during LOAD returns to IDLE without a result.
      seed        = 3'b110;
      len         = 4'd8;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_data", res_data, 0);
      check("abort_ready", start_ready, 1);
      run_vec(vecs[0]);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
